// File: rtl/serial_link.sv
// serial_link: full-duplex 8N1 serial link; define SERIAL_LINK_PARITY_EN to add an even-parity bit (8E1)
module serial_link #(
  parameter int BIT_PERIOD  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       load,
  input  logic       transmit_enable,
  output logic       char_sent,
  output logic [7:0] data_out,
  output logic       char_received,
  output logic       serial_out,
  input  logic       serial_in
);
  localparam int CW = $clog2(BIT_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(BIT_PERIOD - 1);
  localparam logic [CW-1:0] HALF = CW'(BIT_PERIOD / 2 - 1);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
`ifdef SERIAL_LINK_PARITY_EN
  localparam logic [2:0] S_PAR   = 3'd5;
  localparam logic [2:0] S_TAIL  = S_PAR;
`else
  localparam logic [2:0] S_TAIL  = S_STOP;
`endif

  logic [2:0]    tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic [7:0]    hold;
  logic          hold_valid;
  logic          tx_tick;
  logic          tx_take;
  logic          tx_tail;

  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  logic [2:0]             rx_state;
  logic [CW-1:0]          rx_cnt;
  logic [2:0]             rx_bit;
  logic [7:0]             rx_shift;
  logic                   rx_mid;

`ifdef SERIAL_LINK_PARITY_EN
  logic tx_par;
  assign tx_tail = tx_par;
`else
  assign tx_tail = 1'b1;
`endif

  // bit-boundary, frame-start and mid-bit sample strobes
  always_comb begin
    tx_tick = tx_cnt == LAST;
    tx_take = (tx_state == S_IDLE) && hold_valid && transmit_enable;
    rx_s    = sync[SYNC_STAGES-1];
    rx_mid  = (rx_state == S_START) ? rx_cnt == HALF : rx_cnt == LAST;
  end

  // holding register: a new load always wins over consumption by the TX FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      hold       <= '0;
      hold_valid <= 1'b0;
    end else begin
      hold       <= load ? data_in : hold;
      hold_valid <= load || (hold_valid && !tx_take);
    end
  end

  // TX FSM: start bit, 8 data bits LSB first, optional parity, stop bit
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state   <= S_IDLE;
      tx_cnt     <= '0;
      tx_bit     <= '0;
      tx_shift   <= '0;
      serial_out <= 1'b1;
      char_sent  <= 1'b0;
`ifdef SERIAL_LINK_PARITY_EN
      tx_par     <= 1'b0;
`endif
    end else begin
      char_sent <= 1'b0;
      tx_cnt    <= (tx_state == S_IDLE || tx_tick) ? '0 : tx_cnt + 1'b1;
      case (tx_state)
        S_IDLE: if (tx_take) begin
          tx_state   <= S_START;
          tx_shift   <= hold;
          tx_bit     <= '0;
          serial_out <= 1'b0;
`ifdef SERIAL_LINK_PARITY_EN
          tx_par     <= ^hold;
`endif
        end
        S_START: if (tx_tick) begin
          tx_state   <= S_DATA;
          serial_out <= tx_shift[0];
          tx_shift   <= {1'b0, tx_shift[7:1]};
        end
        S_DATA: if (tx_tick) begin
          tx_bit <= tx_bit + 1'b1;
          if (tx_bit == 3'd7) begin
            tx_state   <= S_TAIL;
            serial_out <= tx_tail;
          end else begin
            serial_out <= tx_shift[0];
            tx_shift   <= {1'b0, tx_shift[7:1]};
          end
        end
`ifdef SERIAL_LINK_PARITY_EN
        S_PAR: if (tx_tick) begin
          tx_state   <= S_STOP;
          serial_out <= 1'b1;
        end
`endif
        S_STOP: if (tx_tick) begin
          tx_state  <= S_IDLE;
          char_sent <= 1'b1;
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  // serial_in synchroniser, reset to the idle-high line level
  always_ff @(posedge clk) begin
    sync <= reset ? '1 : {sync[SYNC_STAGES-2:0], serial_in};
  end

  // RX FSM: mid-bit sampling; bad stop or parity waits for an idle line before re-arming
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state      <= S_IDLE;
      rx_cnt        <= '0;
      rx_bit        <= '0;
      rx_shift      <= '0;
      data_out      <= '0;
      char_received <= 1'b0;
    end else begin
      char_received <= 1'b0;
      rx_cnt        <= (rx_state == S_IDLE || rx_state == S_WAIT || rx_mid) ? '0 : rx_cnt + 1'b1;
      case (rx_state)
        S_IDLE: if (!rx_s) begin
          rx_state <= S_START;
          rx_bit   <= '0;
        end
        S_START: if (rx_mid) rx_state <= rx_s ? S_IDLE : S_DATA;
        S_DATA: if (rx_mid) begin
          rx_shift <= {rx_s, rx_shift[7:1]};
          rx_bit   <= rx_bit + 1'b1;
          if (rx_bit == 3'd7) rx_state <= S_TAIL;
        end
`ifdef SERIAL_LINK_PARITY_EN
        S_PAR: if (rx_mid) rx_state <= (rx_s == ^rx_shift) ? S_STOP : S_WAIT;
`endif
        S_STOP: if (rx_mid) begin
          if (rx_s) begin
            data_out      <= rx_shift;
            char_received <= 1'b1;
            rx_state      <= S_IDLE;
          end else begin
            rx_state <= S_WAIT;
          end
        end
        S_WAIT: if (rx_s) rx_state <= S_IDLE;
        default: rx_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_link.sv
// tb_serial_link: randomized self-checking bench for serial_link against a frame-level model
module tb_serial_link;
  localparam int BP = 16;
`ifdef SERIAL_LINK_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic       transmit_enable = 1'b0;
  logic       serial_in_drv = 1'b1;
  logic       loop = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       char_sent, char_received, serial_out, serial_in;
  logic [7:0] exp_data;
  int         tests = 0;
  int         fails = 0;
  int         rx_pulses = 0;
  int         tx_pulses = 0;

  assign serial_in = loop ? serial_out : serial_in_drv;

  serial_link #(.BIT_PERIOD(BP), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .reset(reset),
    .data_in(data_in),
    .load(load),
    .transmit_enable(transmit_enable),
    .char_sent(char_sent),
    .data_out(data_out),
    .char_received(char_received),
    .serial_out(serial_out),
    .serial_in(serial_in)
  );

  always #5 clk = ~clk;

  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef SERIAL_LINK_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
    rx_pulses += int'(char_received);
    tx_pulses += int'(char_sent);
  endtask

  task automatic tx_expect(input logic [7:0] b, input logic do_next, input logic [7:0] nxt);
    tx_pulses = 0;
    for (int i = 0; i < NB * BP; i++) begin
      if (do_next && i == 20) begin
        data_in = nxt;
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      tick;
      tests++;
      if (serial_out !== frame_bit(b, i / BP)) begin
        fails++;
        $display("FAIL tx_bit byte=%h cycle=%0d serial_out=%b want=%b", b, i, serial_out, frame_bit(b, i / BP));
      end
    end
    load = 1'b0;
    tick;
    tests++;
    if (tx_pulses !== 1 || char_sent !== 1'b1 || serial_out !== 1'b1) begin
      fails++;
      $display("FAIL tx_end byte=%h char_sent=%b pulses=%0d serial_out=%b want 1 1 1", b, char_sent, tx_pulses, serial_out);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    for (int i = 0; i < NB; i++) begin
      serial_in_drv = (i == NB - 1) ? stop : frame_bit(b, i);
      repeat (BP) tick;
    end
    serial_in_drv = 1'b1;
    repeat (2 * BP) tick;
  endtask

  task automatic check_rx(input string name, input int want_pulses);
    tests++;
    if (rx_pulses !== want_pulses || data_out !== exp_data) begin
      fails++;
      $display("FAIL %s char_received pulses=%0d data_out=%h want pulses=%0d data_out=%h", name, rx_pulses, data_out, want_pulses, exp_data);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) tick;
    reset = 1'b0;
    exp_data = 8'h00;
    for (int i = 0; i < 100; i++) begin
      tick;
      tests++;
      if ({serial_out, char_sent, char_received, data_out} !== 11'b100_0000_0000) begin
        fails++;
        $display("FAIL reset_idle cycle=%0d so=%b cs=%b cr=%b do=%h want 1 0 0 00", i, serial_out, char_sent, char_received, data_out);
      end
    end
  endtask

  task automatic test_tx_basic;
    loop = 1'b0;
    transmit_enable = 1'b1;
    data_in = 8'hA5;
    load = 1'b1;
    tick;
    load = 1'b0;
    tests++;
    if (serial_out !== 1'b1) begin
      fails++;
      $display("FAIL tx_load_edge serial_out=%b want 1", serial_out);
    end
    tx_expect(8'hA5, 1'b0, 8'h00);
    tick;
    tests++;
    if (char_sent !== 1'b0 || serial_out !== 1'b1) begin
      fails++;
      $display("FAIL tx_after char_sent=%b serial_out=%b want 0 1", char_sent, serial_out);
    end
  endtask

  task automatic test_loopback;
    logic [7:0] bytes [6];
    bytes[0] = 8'h3C;
    bytes[1] = 8'hFF;
    for (int k = 2; k < 6; k++) bytes[k] = 8'($urandom);
    loop = 1'b1;
    transmit_enable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      rx_pulses = 0;
      data_in = bytes[k];
      load = 1'b1;
      tick;
      load = 1'b0;
      tx_expect(bytes[k], 1'b0, 8'h00);
      repeat (3) tick;
      exp_data = bytes[k];
      check_rx("loopback", 1);
    end
  endtask

  task automatic test_hold_overwrite;
    loop = 1'b1;
    transmit_enable = 1'b0;
    rx_pulses = 0;
    data_in = 8'h11;
    load = 1'b1;
    tick;
    data_in = 8'h22;
    tick;
    load = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick;
      tests++;
      if (serial_out !== 1'b1) begin
        fails++;
        $display("FAIL hold_blocked cycle=%0d serial_out=%b want 1", i, serial_out);
      end
    end
    transmit_enable = 1'b1;
    tx_expect(8'h22, 1'b0, 8'h00);
    for (int i = 0; i < 3 * BP; i++) begin
      tick;
      tests++;
      if (serial_out !== 1'b1) begin
        fails++;
        $display("FAIL hold_single_frame cycle=%0d serial_out=%b want 1", i, serial_out);
      end
    end
    tests++;
    if (tx_pulses !== 1) begin
      fails++;
      $display("FAIL hold_char_sent pulses=%0d want 1", tx_pulses);
    end
    exp_data = 8'h22;
    check_rx("hold_rx", 1);
  endtask

  task automatic test_back_to_back;
    logic [7:0] b1, b2;
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    loop = 1'b1;
    transmit_enable = 1'b1;
    rx_pulses = 0;
    data_in = b1;
    load = 1'b1;
    tick;
    load = 1'b0;
    tx_expect(b1, 1'b1, b2);
    tx_expect(b2, 1'b0, 8'h00);
    repeat (3) tick;
    exp_data = b2;
    check_rx("back_to_back", 2);
  endtask

  task automatic test_rx_errors;
    logic [7:0] b;
    logic       ok;
    loop = 1'b0;
    serial_in_drv = 1'b1;
    rx_pulses = 0;
    serial_in_drv = 1'b0;
    repeat (4) tick;
    serial_in_drv = 1'b1;
    repeat (2 * BP) tick;
    check_rx("rx_glitch", 0);
    rx_pulses = 0;
    send_frame(8'($urandom), 1'b0);
    check_rx("rx_framing", 0);
    rx_pulses = 0;
    send_frame(8'h5A, 1'b1);
    exp_data = 8'h5A;
    check_rx("rx_good_5a", 1);
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom);
      ok = 1'($urandom_range(0, 1));
      rx_pulses = 0;
      send_frame(b, ok);
      if (ok) exp_data = b;
      check_rx(ok ? "rx_rand_good" : "rx_rand_bad", ok ? 1 : 0);
    end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] b;
    b = 8'($urandom);
    loop = 1'b1;
    transmit_enable = 1'b1;
    data_in = 8'($urandom);
    load = 1'b1;
    tick;
    load = 1'b0;
    repeat (4 * BP + BP / 2) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    exp_data = 8'h00;
    tests++;
    if (serial_out !== 1'b1 || char_sent !== 1'b0 || char_received !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid so=%b cs=%b cr=%b want 1 0 0", serial_out, char_sent, char_received);
    end
    rx_pulses = 0;
    tx_pulses = 0;
    for (int i = 0; i < 12 * BP; i++) begin
      tick;
      tests++;
      if (serial_out !== 1'b1) begin
        fails++;
        $display("FAIL reset_mid_idle cycle=%0d serial_out=%b want 1", i, serial_out);
      end
    end
    tests++;
    if (tx_pulses !== 0) begin
      fails++;
      $display("FAIL reset_mid_char_sent pulses=%0d want 0", tx_pulses);
    end
    check_rx("reset_mid_rx", 0);
    data_in = b;
    load = 1'b1;
    tick;
    load = 1'b0;
    tx_expect(b, 1'b0, 8'h00);
    repeat (3) tick;
    exp_data = b;
    check_rx("reset_mid_recover", 1);
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_loopback();
    test_hold_overwrite();
    test_back_to_back();
    test_rx_errors();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
